// File: rtl/l2_flush_walker_pkg.sv
// Shared types and helpers for the L2 flush walker: FSM state encoding,
// address width and writeback address construction.
package l2_flush_pkg;

    localparam int unsigned AddrW      = 32;
    localparam int unsigned SIndexDef  = 3;
    localparam int unsigned SWayDef    = 1;
    localparam int unsigned SOffsetDef = 5;
    localparam int unsigned STagDef    = 24;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StScan  = 3'd1,
        StWb    = 3'd2,
        StClear = 3'd3,
        StDone  = 3'd4
    } l2_flush_state_t;

    // Line address {tag, index, offset=0}; tag and index arrive zero-extended.
    function automatic logic [AddrW-1:0] make_wb_addr(
        input logic [AddrW-1:0] tag,
        input logic [AddrW-1:0] index,
        input int unsigned      s_index,
        input int unsigned      s_offset
    );
        return (tag << (s_index + s_offset)) | (index << s_offset);
    endfunction

endpackage

// File: rtl/l2_flush_walker_if.sv
// Array-port and writeback bundle between the flush walker (master) and the
// L2 tag/valid/dirty arrays plus memory-side writeback path (slave).
interface l2_flush_walker_if
    import l2_flush_pkg::*;
#(
    parameter int unsigned SIndex = SIndexDef,
    parameter int unsigned SWay   = SWayDef,
    parameter int unsigned STag   = STagDef
) ();

    localparam int unsigned Ways = 2 ** SWay;

    logic [SIndex-1:0]    arr_index;
    logic [Ways-1:0]      valid_rd;
    logic [Ways-1:0]      dirty_rd;
    logic [Ways*STag-1:0] tag_rd;
    logic [Ways-1:0]      dirty_load;
    logic [Ways-1:0]      valid_load;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [AddrW-1:0]     wb_addr;
    logic [SWay-1:0]      wb_way;

    modport master (
        output arr_index,
        input  valid_rd,
        input  dirty_rd,
        input  tag_rd,
        output dirty_load,
        output valid_load,
        output wb_valid,
        input  wb_ready,
        output wb_addr,
        output wb_way
    );

    modport slave (
        input  arr_index,
        output valid_rd,
        output dirty_rd,
        output tag_rd,
        input  dirty_load,
        input  valid_load,
        input  wb_valid,
        output wb_ready,
        input  wb_addr,
        input  wb_way
    );

endinterface

// File: rtl/l2_flush_walker_cursor.sv
// Set/way cursor for the flush walk: way increments first, index on way wrap.
module l2_flush_cursor #(
    parameter int unsigned SIndex = 3,
    parameter int unsigned SWay   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [SIndex-1:0] index_o,
    output logic [SWay-1:0]   way_o,
    output logic              last_o
);

    logic [SIndex-1:0] index_q, index_d;
    logic [SWay-1:0]   way_q, way_d;

    always_comb begin
        index_d = index_q;
        way_d   = way_q;
        if (clear_i) begin
            index_d = '0;
            way_d   = '0;
        end else if (advance_i) begin
            // Way wraps to zero naturally; carry into the index on wrap.
            way_d = way_q + SWay'(1);
            if (&way_q) begin
                index_d = index_q + SIndex'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            way_q   <= '0;
        end else begin
            index_q <= index_d;
            way_q   <= way_d;
        end
    end

    assign index_o = index_q;
    assign way_o   = way_q;
    assign last_o  = (&index_q) & (&way_q);

endmodule

// File: rtl/l2_flush_walker.sv
// L2 flush engine: walks every set/way, writes back valid+dirty lines and
// clears their dirty bits. Define L2_FLUSH_INVAL_EN to also invalidate lines.
module l2_flush_walker
    import l2_flush_pkg::*;
#(
    parameter int unsigned SIndex  = SIndexDef,
    parameter int unsigned SWay    = SWayDef,
    parameter int unsigned SOffset = SOffsetDef,
    parameter int unsigned STag    = STagDef
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  done,
    l2_flush_walker_if.master     bus
);

    localparam int unsigned Ways = 2 ** SWay;

    l2_flush_state_t   state_q, state_d;
    logic [AddrW-1:0]  wb_addr_q, wb_addr_d;
    logic [SWay-1:0]   wb_way_q, wb_way_d;

    logic [SIndex-1:0] cur_index;
    logic [SWay-1:0]   cur_way;
    logic              cur_last;
    logic              cur_clear;
    logic              cur_advance;

    logic              hit;
    logic [STag-1:0]   cur_tag;
    logic [Ways-1:0]   way_oh;
    int unsigned       tag_lsb;

    l2_flush_cursor #(
        .SIndex (SIndex),
        .SWay   (SWay)
    ) u_cursor (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cur_clear),
        .advance_i (cur_advance),
        .index_o   (cur_index),
        .way_o     (cur_way),
        .last_o    (cur_last)
    );

    always_comb begin
        tag_lsb         = 32'(cur_way) * STag;
        cur_tag         = bus.tag_rd[tag_lsb +: STag];
        hit             = bus.valid_rd[cur_way] & bus.dirty_rd[cur_way];
        way_oh          = '0;
        way_oh[cur_way] = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        wb_addr_d      = wb_addr_q;
        wb_way_d       = wb_way_q;
        cur_clear      = 1'b0;
        cur_advance    = 1'b0;
        bus.dirty_load = '0;
        bus.valid_load = '0;
        bus.wb_valid   = 1'b0;
        done           = 1'b0;

        unique case (state_q)
            StIdle: begin
                cur_clear = 1'b1;
                if (flush_req) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (hit) begin
                    // Capture the writeback now so it stays stable across the WB wait.
                    state_d   = StWb;
                    wb_addr_d = make_wb_addr(AddrW'(cur_tag), AddrW'(cur_index),
                                             SIndex, SOffset);
                    wb_way_d  = cur_way;
                end else begin
`ifdef L2_FLUSH_INVAL_EN
                    if (bus.valid_rd[cur_way]) begin
                        bus.valid_load = way_oh;
                    end
`endif
                    if (cur_last) begin
                        state_d = StDone;
                    end else begin
                        cur_advance = 1'b1;
                    end
                end
            end
            StWb: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                bus.dirty_load = way_oh;
`ifdef L2_FLUSH_INVAL_EN
                bus.valid_load = way_oh;
`endif
                if (cur_last) begin
                    state_d = StDone;
                end else begin
                    cur_advance = 1'b1;
                    state_d     = StScan;
                end
            end
            StDone: begin
                done      = 1'b1;
                cur_clear = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wb_addr_q <= '0;
            wb_way_q  <= '0;
        end else begin
            state_q   <= state_d;
            wb_addr_q <= wb_addr_d;
            wb_way_q  <= wb_way_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign bus.arr_index = cur_index;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_way    = wb_way_q;

endmodule
